// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer: buffers 16-bit samples and frames them into paced byte
// packets for uart_tx_core. Define PKT_CRC_EN for a CRC-8 check byte.
module uart_pkt_framer #(
    parameter int DEPTH           = 64,
    parameter int SAMPLES_PER_PKT = 16,
    parameter int BYTE_CYCLES     = 4800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        flush,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(BYTE_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_PKT  = (AW+1)'(SAMPLES_PER_PKT);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {
        IDLE, SYNC0, SYNC1, SEQ, LEN, PAY_HI, PAY_LO, CHK
    } state_t;

    state_t          state;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      seq;
    logic [7:0]      len;
    logic [7:0]      rem;
    logic [7:0]      check;
    logic [7:0]      check_next;
    logic [15:0]     hold_reg;
    logic [7:0]      cur_byte;
    logic            full;
    logic            push;
    logic            pop;
    logic            emit;

`ifdef PKT_CRC_EN
    // CRC-8 poly 0x07, MSB-first, folded one byte at a time
    function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction
`else
    // mod-256 running sum
    function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] d);
        return c + d;
    endfunction
`endif

    assign full     = (level == LVL_FULL);
    assign s_ready  = !full;
    assign push     = s_valid && s_ready;
    assign emit     = (state != IDLE) && (gap_cnt == '0);
    assign pop      = emit && (state == PAY_HI);

    // select the byte for the current state
    always_comb begin
        cur_byte = 8'h00;
        unique case (state)
            IDLE:   cur_byte = 8'h00;
            SYNC0:  cur_byte = 8'hA5;
            SYNC1:  cur_byte = 8'h5A;
            SEQ:    cur_byte = seq;
            LEN:    cur_byte = len;
            PAY_HI: cur_byte = mem[rd_ptr][15:8];
            PAY_LO: cur_byte = hold_reg[7:0];
            CHK:    cur_byte = check;
        endcase
        check_next = fold(check, cur_byte);
    end

    // sample storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) level <= level + LVL_ONE;
            else if (pop && !push) level <= level - LVL_ONE;
        end
    end

    // sticky overflow on a refused sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if (s_valid && !s_ready) overflow <= 1'b1;
    end

    // packet FSM with byte pacing and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            seq      <= 8'h00;
            len      <= 8'h00;
            rem      <= 8'h00;
            check    <= 8'h00;
            hold_reg <= 16'h0000;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (emit) begin
                tx_valid <= 1'b1;
                tx_data  <= cur_byte;
                gap_cnt  <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (level >= LVL_PKT) begin
                        len   <= 8'(SAMPLES_PER_PKT);
                        rem   <= 8'(SAMPLES_PER_PKT);
                        check <= 8'h00;
                        busy  <= 1'b1;
                        state <= SYNC0;
                    end else if (flush && level != '0) begin
                        len   <= 8'(level);
                        rem   <= 8'(level);
                        check <= 8'h00;
                        busy  <= 1'b1;
                        state <= SYNC0;
                    end
                end
                SYNC0: if (emit) state <= SYNC1;
                SYNC1: if (emit) state <= SEQ;
                SEQ: if (emit) begin
                    check <= check_next;
                    state <= LEN;
                end
                LEN: if (emit) begin
                    check <= check_next;
                    state <= PAY_HI;
                end
                PAY_HI: if (emit) begin
                    check    <= check_next;
                    hold_reg <= mem[rd_ptr];
                    rem      <= rem - 8'd1;
                    state    <= PAY_LO;
                end
                PAY_LO: if (emit) begin
                    check <= check_next;
                    state <= (rem != 8'd0) ? PAY_HI : CHK;
                end
                CHK: if (emit) begin
                    seq   <= seq + 8'd1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_framer.sv
// tb_uart_pkt_framer: directed and randomized packet checks against a
// packet-level reference model (DEPTH=4, 2 samples/packet, 8-cycle pacing).
module tb_uart_pkt_framer;

    localparam int DEPTH = 4;
    localparam int SPP   = 2;
    localparam int BC    = 8;

    typedef logic [7:0]  bq_t [$];
    typedef logic [15:0] wq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = 16'h0;
    logic        s_valid = 1'b0;
    logic        flush = 1'b0;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overflow;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bq_t  got_q;
    int   stamp_q[$];
    logic busy_q[$];
    logic [7:0] exp_seq;

    uart_pkt_framer #(
        .DEPTH(DEPTH),
        .SAMPLES_PER_PKT(SPP),
        .BYTE_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .flush(flush),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // record every strobe with its cycle and the busy level
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            got_q.push_back(tx_data);
            stamp_q.push_back(cyc);
            busy_q.push_back(busy);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] check_of(input bq_t body);
`ifdef PKT_CRC_EN
        // remainder of message * x^8 divided by x^8+x^2+x+1
        logic [8:0] r;
        r = 9'h0;
        for (int i = 0; i < body.size() + 1; i++) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[7:0], (i < body.size()) ? body[i][b] : 1'b0};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
`else
        int s;
        s = 0;
        foreach (body[i]) s += int'(body[i]);
        return 8'(s % 256);
`endif
    endfunction

    function automatic bq_t build_pkt(input logic [7:0] sq, input wq_t w);
        bq_t body;
        bq_t p;
        body.push_back(sq);
        body.push_back(8'(w.size()));
        foreach (w[i]) begin
            body.push_back(w[i][15:8]);
            body.push_back(w[i][7:0]);
        end
        p.push_back(8'hA5);
        p.push_back(8'h5A);
        foreach (body[i]) p.push_back(body[i]);
        p.push_back(check_of(body));
        return p;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        stamp_q.delete();
        busy_q.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        s_data = w;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        clear_mon();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_pkt(input bq_t exp, input string tag);
        int n;
        int t;
        n = exp.size();
        t = 0;
        while (got_q.size() < n && t < (n + 2) * BC + 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (got_q.size() < n) begin
            chk({tag, " byte_count"}, got_q.size(), n);
            clear_mon();
            return;
        end
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s byte%0d", tag, i), got_q[i], exp[i]);
            chk($sformatf("%s busy%0d", tag, i), busy_q[i], (i < n - 1));
            if (i > 0)
                chk($sformatf("%s gap%0d", tag, i), stamp_q[i] - stamp_q[i-1], BC);
        end
        repeat (n) begin
            void'(got_q.pop_front());
            void'(stamp_q.pop_front());
            void'(busy_q.pop_front());
        end
    endtask

    initial begin
        bq_t  e;
        wq_t  w;
        int   t;
        int   n;

        exp_seq = 8'h00;
        #2;
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(3);

        // full packet of two samples
        w = {16'h1234, 16'hABCD};
        push_word(w[0]);
        push_word(w[1]);
        expect_pkt(build_pkt(exp_seq, w), "pkt2");
        exp_seq++;
        wait_cycles(2);
        chk("busy after pkt2", busy, 1'b0);

        // short packet by flush from fresh reset
        do_reset();
        exp_seq = 8'h00;
        push_word(16'h0001);
        pulse_flush();
`ifdef PKT_CRC_EN
        e = {8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h01, 8'h6C};
`else
        e = {8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02};
`endif
        expect_pkt(e, "flush1");
        exp_seq++;

        // flush with empty FIFO does nothing
        wait_cycles(10);
        pulse_flush();
        wait_cycles(40);
        chk("empty flush strobes", got_q.size(), 0);
        chk("empty flush busy", busy, 1'b0);

        // overflow: five back-to-back pushes into a 4-deep FIFO
        w = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int i = 0; i < 5; i++) begin
            s_data = w[i];
            s_valid = 1'b1;
            chk($sformatf("ovf s_ready%0d", i), s_ready, (i < DEPTH));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("ovf sticky", overflow, 1'b1);
        expect_pkt(build_pkt(exp_seq, {w[0], w[1]}), "ovf_a");
        exp_seq++;
        expect_pkt(build_pkt(exp_seq, {w[2], w[3]}), "ovf_b");
        exp_seq++;
        wait_cycles(20);
        chk("ovf no extra", got_q.size(), 0);
        chk("ovf still set", overflow, 1'b1);

        // asynchronous reset while the packet sits in PAY_LO
        push_word(16'hBEEF);
        push_word(16'hCAFE);
        t = 0;
        while (got_q.size() < 5 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("mid reach pay_lo", (got_q.size() >= 5), 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst tx_valid", tx_valid, 1'b0);
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst overflow", overflow, 1'b0);
        chk("mid rst s_ready", s_ready, 1'b1);
        clear_mon();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(60);
        chk("post rst quiet", got_q.size(), 0);
        chk("post rst busy", busy, 1'b0);
        exp_seq = 8'h00;
        w = {16'h0F0F, 16'hF00D};
        push_word(w[0]);
        push_word(w[1]);
        expect_pkt(build_pkt(exp_seq, w), "post_rst");
        exp_seq++;

        // randomized packets, long enough to wrap the sequence number
        for (int p = 0; p < 257; p++) begin
            w.delete();
            n = $urandom_range(1, SPP);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            foreach (w[i]) push_word(w[i]);
            if (n < SPP) pulse_flush();
            expect_pkt(build_pkt(exp_seq, w), $sformatf("rnd%0d", p));
            exp_seq++;
        end
        wait_cycles(20);
        chk("final quiet", got_q.size(), 0);
        chk("final overflow", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_pkt_framer.md
Name: uart_pkt_framer

Overview:
- Upstream feeder for uart_tx_core.
- Buffers 16-bit TDR samples in an internal FIFO and frames them into byte packets: sync, sequence, length, payload, check byte.
- Drives the byte-wide data/valid input of uart_tx_core with single-cycle strobes.
- uart_tx_core has no ready/busy output, so this block paces strobes itself using a fixed byte-period counter. This guarantees a byte is never presented while a previous byte is still being shifted out.

Parameters:
- DEPTH, 64, FIFO depth in 16-bit samples; must be a power of 2, at least 2.
- SAMPLES_PER_PKT, 16, maximum samples per packet; range 1..255, and at most DEPTH.
- BYTE_CYCLES, 4800, clk cycles between successive tx_valid strobes. Must be at least 11*(BAUD_DIV+1), i.e. 4785 at 115200 baud / 50 MHz.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- s_data  in  16  sample word
- s_valid  in  1  sample valid
- s_ready  out  1  FIFO can accept a sample; equals !full
- flush  in  1  single-cycle request to send a short packet from whatever the FIFO holds
- tx_data  out  8  byte to uart_tx_core data_in
- tx_valid  out  1  single-cycle strobe to uart_tx_core data_valid
- busy  out  1  high whenever the state machine is not in IDLE
- overflow  out  1  sticky; set when s_valid=1 while s_ready=0; cleared only by rst

Behaviour:
Reset (asynchronous, any state, including mid-packet):
- FIFO emptied, state=IDLE, seq=0, gap_cnt=0, check=0.
- tx_valid=0, tx_data=0x00, busy=0, overflow=0, s_ready=1.
- A partially sent packet is abandoned; no resume.

FIFO:
- A push occurs when s_valid & s_ready.
- A pop occurs only on the PAY_HI byte emission; the popped word is latched into hold_reg.
- Push and pop in the same cycle are both allowed; level is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- s_ready is combinational from the full flag.

Packet start (IDLE only):
- Start when level >= SAMPLES_PER_PKT: len = SAMPLES_PER_PKT.
- Otherwise, start when flush=1 and level > 0: len = level, sampled that cycle.
- flush with an empty FIFO, or flush outside IDLE, is ignored (not queued).

Byte sequence:
- A5, 5A, seq, len, then for each sample MSB byte (PAY_HI) and LSB byte (PAY_LO), then the check byte (CHK).
- Total bytes per packet = 5 + 2*len.
- States: IDLE -> SYNC0 -> SYNC1 -> SEQ -> LEN -> PAY_HI <-> PAY_LO -> CHK -> IDLE.
- PAY_LO goes to PAY_HI while samples remain, otherwise to CHK.

Pacing:
- gap_cnt is a down-counter.
- In any non-IDLE state, a byte is emitted in the cycle gap_cnt==0: tx_valid=1, tx_data=byte, gap_cnt loads BYTE_CYCLES-1, and the state advances.
- Otherwise gap_cnt decrements, saturating at 0, including while in IDLE.
- The first byte of a packet is emitted the cycle after leaving IDLE if gap_cnt is already 0.
- tx_valid is registered and never high on two consecutive cycles.

Check byte (default):
- 8-bit sum mod 256 of the seq, len and all payload bytes. Sync bytes are excluded.
- The accumulator clears on leaving IDLE.

Sequence number:
- seq increments on CHK emission; wraps 255 -> 0.

busy:
- High from the cycle after leaving IDLE through the CHK emission cycle.

Optional Feature:
- Macro PKT_CRC_EN.
- When defined: the check byte is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR), computed MSB-first over the same byte set as the sum (seq, len, payload). Computation is byte-at-a-time combinational, updated on each emission.
- When undefined: the check byte is the mod-256 sum, and no CRC logic is synthesised.
- All other behaviour, including packet length and timing, is identical in both builds.

Test Plan:
- SAMPLES_PER_PKT=2, BYTE_CYCLES=8; push 0x1234, 0xABCD -> tx bytes A5 5A 00 02 12 34 AB CD C0. Strobes exactly 8 cycles apart; busy falls after CHK; seq becomes 1.
- Same config; push 0x0001 then pulse flush -> A5 5A 00 01 00 01 02. With PKT_CRC_EN, last byte is 0x6C.
- DEPTH=4, hold off draining by starting with an empty FIFO and flush never asserted; push 5 words -> s_ready low after the 4th, overflow=1, the 5th word is dropped. Next packet payload is the first 4 words only (SAMPLES_PER_PKT=4).
- Assert rst asynchronously mid-PAY_LO -> tx_valid, busy and overflow are 0 immediately. After release: no strobes until new data arrives, and the next packet uses seq=00.
- Send 257 packets of 1 sample -> seq bytes run 00..FF then 00.
- BYTE_CYCLES=4785 with a real uart_tx_core (BAUD_DIV=434) -> a UART monitor on tx decodes the full packet with no framing errors.
